alu_bit_serial_sequencer: RTL and testbench

Bit-serial execute controller that drives a single 1-bit ALU slice to evaluate one full-width ALU operation. It accepts operands and a 4-bit ALU control word through a start/ready handshake. It then feeds the slice one bit pair per cycle, LSB first, carrying CarryOut back into CarryIn, and assembles the full-width result and status flags. It sits between the decode/register-read stage and the slice, giving a low-area alternative to the 24-slice ripple ALU.

---
 rtl/alu_bit_serial_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_alu_bit_serial_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_bit_serial_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_bit_serial_sequencer
// Purpose  : Drives one combinational 1-bit ALU slice through a full-width
//            operation, LSB first, chaining CarryOut back into CarryIn, and
//            assembles the full-width result plus Zero/Overflow/CarryOut.
//            One operation takes WIDTH+2 cycles from start to ready.
// Revision : 1.0 - initial release
// ============================================================================
module alu_bit_serial_sequencer #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  // request handshake
  input  logic             start,
  output logic             ready,
  input  logic [3:0]       ALUCtl,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  // slice drive
  output logic             SliceA,
  output logic             SliceB,
  output logic             SliceAInvert,
  output logic             SliceBInvert,
  output logic             SliceCarryIn,
  output logic             SliceLess,
  output logic [2:0]       SliceOperation,
  // slice response (combinational from the drive above)
  input  logic             SliceResult,
  input  logic             SliceCarryOut,
  // completed-operation outputs
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             CarryOut,
  output logic             done
);

  localparam int              IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         ctl_q, ctl_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               cout_q, cout_d;

  // Decoded view of the latched control word
  logic [1:0]         w_op;
  logic               w_is_arith;
  logic               w_is_addsub;
  logic               w_is_slt;
  logic               w_last;
  logic               w_run;

  // Final-bit datapath
  logic               w_ovf;
  logic               w_set;
  logic [WIDTH-1:0]   w_acc_ins;
  logic [WIDTH-1:0]   w_final;

  assign w_op        = ctl_q[1:0];
  assign w_is_arith  = w_op[1];
  assign w_is_addsub = (w_op == 2'b10);
  assign w_is_slt    = (w_op == 2'b11);
  assign w_last      = (idx_q == LAST_IDX);
  assign w_run       = (state_q == RUN);

  // Overflow compares the carry into the MSB with the carry out of it;
  // the SLT set bit is the true sign of A-B, corrected for overflow.
  assign w_ovf       = carry_q ^ SliceCarryOut;
  assign w_set       = SliceResult ^ w_ovf;
  assign w_final     = w_is_slt ? {{(WIDTH-1){1'b0}}, w_set} : w_acc_ins;

  // Insert the slice's current result bit into the assembled word
  always_comb begin
    w_acc_ins        = acc_q;
    w_acc_ins[idx_q] = SliceResult;
  end

  // Slice drive: everything is held at 0 outside RUN so the slice is quiet
  always_comb begin
    SliceA         = w_run & a_q[idx_q];
    SliceB         = w_run & b_q[idx_q];
    SliceAInvert   = w_run & ctl_q[3];
    SliceBInvert   = w_run & ctl_q[2];
    SliceCarryIn   = w_run & carry_q;
    SliceLess      = 1'b0;
    SliceOperation = 3'b000;
    if (w_run) begin
      // SLT evaluates A-B through the adder path; the set bit is formed here
      SliceOperation = w_is_slt ? 3'b010 : {1'b0, w_op};
    end
  end

  // Next-state and datapath updates for the IDLE -> RUN -> DONE sequence
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ctl_d    = ctl_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = OpA;
          b_d     = OpB;
          ctl_d   = ALUCtl;
          idx_d   = '0;
          // BInvert doubles as the +1 of two's-complement subtraction
          carry_d = ALUCtl[2];
          acc_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        acc_d   = w_acc_ins;
        carry_d = SliceCarryOut;
        if (w_last) begin
          idx_d    = '0;
          result_d = w_final;
          zero_d   = (w_final == '0);
          ovf_d    = w_is_addsub & w_ovf;
          cout_d   = w_is_arith & SliceCarryOut;
          state_d  = DONE;
        end else begin
          idx_d    = idx_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ctl_q    <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctl_q    <= ctl_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = (state_q == DONE);
  assign Result   = result_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;
  assign CarryOut = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_bit_serial_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_bit_serial_sequencer
// Purpose  : Directed-vector bench for alu_bit_serial_sequencer with a
//            behavioural 1-bit slice and a queue-based result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_bit_serial_sequencer;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         ready;
  logic [3:0]   ALUCtl;
  logic [W-1:0] OpA, OpB;
  logic         SliceA, SliceB, SliceAInvert, SliceBInvert;
  logic         SliceCarryIn, SliceLess;
  logic [2:0]   SliceOperation;
  logic         SliceResult, SliceCarryOut;
  logic [W-1:0] Result;
  logic         Zero, Overflow, CarryOut, done;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         o;
    logic         c;
    logic [7:0]   id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  alu_bit_serial_sequencer #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .ready          (ready),
    .ALUCtl         (ALUCtl),
    .OpA            (OpA),
    .OpB            (OpB),
    .SliceA         (SliceA),
    .SliceB         (SliceB),
    .SliceAInvert   (SliceAInvert),
    .SliceBInvert   (SliceBInvert),
    .SliceCarryIn   (SliceCarryIn),
    .SliceLess      (SliceLess),
    .SliceOperation (SliceOperation),
    .SliceResult    (SliceResult),
    .SliceCarryOut  (SliceCarryOut),
    .Result         (Result),
    .Zero           (Zero),
    .Overflow       (Overflow),
    .CarryOut       (CarryOut),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Behavioural 1-bit ALU slice (AND / OR / ADD / Less)
  logic m_a, m_b;
  always_comb begin
    m_a           = SliceA ^ SliceAInvert;
    m_b           = SliceB ^ SliceBInvert;
    SliceCarryOut = (m_a & m_b) | (m_a & SliceCarryIn) | (m_b & SliceCarryIn);
    case (SliceOperation)
      3'b000:  SliceResult = m_a & m_b;
      3'b001:  SliceResult = m_a | m_b;
      3'b010:  SliceResult = m_a ^ m_b ^ SliceCarryIn;
      3'b011:  SliceResult = SliceLess;
      default: SliceResult = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s (op %0d): got %h required %h", nm, id, act, expv);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected done", 0, 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("Result",   int'(mon_e.id), 32'(Result),   32'(mon_e.res));
        chk("Zero",     int'(mon_e.id), 32'(Zero),     32'(mon_e.z));
        chk("Overflow", int'(mon_e.id), 32'(Overflow), 32'(mon_e.o));
        chk("CarryOut", int'(mon_e.id), 32'(CarryOut), 32'(mon_e.c));
      end
    end
  end

  // Issue one operation starting at the next falling edge. Operand inputs are
  // scrambled after acceptance to prove they were latched. inject pulses
  // start during RUN (cycle 10) and DONE (last cycle); abort_at>0 pulls
  // rst_n low in that cycle instead of letting the operation finish.
  task automatic run_op(input int id, input logic [3:0] ctl,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ez,
                        input logic eo, input logic ec,
                        input bit inject, input int abort_at);
    exp_t       e;
    logic [2:0] eop;
    eop = (ctl[1:0] == 2'b11) ? 3'b010 : {1'b0, ctl[1:0]};
    @(negedge clk);
    chk("ready before start", id, 32'(ready), 32'd1);
    if (abort_at == 0) begin
      e.res = er; e.z = ez; e.o = eo; e.c = ec; e.id = 8'(id);
      exp_q.push_back(e);
    end
    start  = 1'b1;
    ALUCtl = ctl;
    OpA    = a;
    OpB    = b;
    @(posedge clk);
    for (int c = 1; c <= W + 1; c++) begin
      @(negedge clk);
      chk("ready low", id, 32'(ready), 32'd0);
      chk("done timing", id, 32'(done), 32'(c == W + 1));
      if (c == 1) begin
        chk("SliceA bit0",    id, 32'(SliceA),         32'(a[0]));
        chk("SliceB bit0",    id, 32'(SliceB),         32'(b[0]));
        chk("SliceAInvert",   id, 32'(SliceAInvert),   32'(ctl[3]));
        chk("SliceBInvert",   id, 32'(SliceBInvert),   32'(ctl[2]));
        chk("SliceCarryIn0",  id, 32'(SliceCarryIn),   32'(ctl[2]));
        chk("SliceOperation", id, 32'(SliceOperation), 32'(eop));
        chk("SliceLess",      id, 32'(SliceLess),      32'd0);
        OpA    = W'($urandom);
        OpB    = W'($urandom);
        ALUCtl = 4'($urandom);
      end
      if (c == 2) begin
        chk("SliceA bit1", id, 32'(SliceA), 32'(a[1]));
        chk("SliceB bit1", id, 32'(SliceB), 32'(b[1]));
      end
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort ready",    id, 32'(ready),    32'd1);
        chk("abort done",     id, 32'(done),     32'd0);
        chk("abort Result",   id, 32'(Result),   32'd0);
        chk("abort Overflow", id, 32'(Overflow), 32'd0);
        chk("abort SliceA",   id, 32'(SliceA),   32'd0);
        chk("abort SliceOp",  id, 32'(SliceOperation), 32'd0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-abort ready",  id, 32'(ready),  32'd1);
        chk("post-abort Result", id, 32'(Result), 32'd0);
        return;
      end
      start = inject && (c == 10 || c == W + 1);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    ALUCtl = 4'h0;
    OpA    = '0;
    OpB    = '0;
    repeat (3) @(negedge clk);
    chk("reset ready",    0, 32'(ready),    32'd1);
    chk("reset done",     0, 32'(done),     32'd0);
    chk("reset Result",   0, 32'(Result),   32'd0);
    chk("reset Zero",     0, 32'(Zero),     32'd0);
    chk("reset Overflow", 0, 32'(Overflow), 32'd0);
    chk("reset CarryOut", 0, 32'(CarryOut), 32'd0);
    chk("reset Slice",    0,
        32'({SliceA, SliceB, SliceAInvert, SliceBInvert, SliceCarryIn,
             SliceLess, SliceOperation}), 32'd0);
    rst_n = 1'b1;

    //      id ctl     OpA        OpB        Result     Z     O     C     inj abort
    run_op(1, 4'b0010, 24'h000001, 24'h000002, 24'h000003, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op(2, 4'b0010, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, 1'b0, 1'b1, 0, 0);
    run_op(3, 4'b0110, 24'h7FFFFF, 24'hFFFFFF, 24'h800000, 1'b0, 1'b1, 1'b0, 0, 0);
    run_op(4, 4'b0010, 24'h123456, 24'h111111, 24'h000000, 1'b0, 1'b0, 1'b0, 0, 10);
    run_op(5, 4'b0110, 24'h000005, 24'h000005, 24'h000000, 1'b1, 1'b0, 1'b1, 0, 0);
    run_op(6, 4'b0111, 24'hFFFFFB, 24'h000003, 24'h000001, 1'b0, 1'b0, 1'b1, 0, 0);
    run_op(7, 4'b0111, 24'h7FFFFF, 24'h800000, 24'h000000, 1'b1, 1'b0, 1'b0, 0, 0);
    run_op(8, 4'b1100, 24'h0F0F0F, 24'h00FF00, 24'hF000F0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(9, 4'b0000, 24'h0F0F0F, 24'h00FF00, 24'h000F00, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(10, 4'b0001, 24'h0F0F0F, 24'h00FF00, 24'h0FFF0F, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(11, 4'b1101, 24'h0F0F0F, 24'h00FF00, 24'hFFF0FF, 1'b0, 1'b0, 1'b0, 0, 0);

    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("results held", 11, 32'(Result), 32'hFFF0FF);
    chk("pending expectations", 0, 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
